// File: rtl/reg_file_param.sv
// Parametrised register file: NUM_REGS x DATA_W, two combinational read ports, one write port,
// optional write-to-read forwarding, optional hardwired-zero r0 and a one-entry-per-cycle clear sweep.
module reg_file_param #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int R0_ZERO  = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] busW,
  input  logic              r_type,
  input  logic              reg_wr,
  input  logic              clear,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic              busy,
  output logic              clear_done,
  output logic              wr_drop
);

  localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] LAST_C     = (ADDR_W+1)'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              busy_q, clear_done_q, wr_drop_q, wr_drop_d;

  logic [ADDR_W-1:0] waddr_s;
  logic              in_range_s, r0_hit_s, idle_s, wr_commit_s;
  logic [DATA_W-1:0] stored_a_s, stored_b_s;

  // Final read mux: range check, then r0 masking, then forwarding, then stored value.
  function automatic logic [DATA_W-1:0] sel_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              commit,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    if ({1'b0, addr} >= NUM_REGS_C) begin
      val = '0;
    end else if ((R0_ZERO != 0) && (addr == '0)) begin
      val = '0;
    end else if ((BYPASS != 0) && commit && (addr == wa)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Write decode: destination, legality and drop detection.
  always_comb begin
    waddr_s     = r_type ? rd : rs2;
    in_range_s  = ({1'b0, waddr_s} < NUM_REGS_C);
    r0_hit_s    = (R0_ZERO != 0) && (waddr_s == '0);
    idle_s      = (state_q == IDLE);
    wr_commit_s = reg_wr && idle_s && in_range_s && !r0_hit_s;
    wr_drop_d   = reg_wr && (!idle_s || !in_range_s);
  end

  // Raw array lookups, guarded so out-of-range addresses never index the array.
  always_comb begin
    stored_a_s = '0;
    stored_b_s = '0;
    if ({1'b0, rs} < NUM_REGS_C) begin
      stored_a_s = regs_q[rs];
    end else begin
      stored_a_s = '0;
    end
    if ({1'b0, rs2} < NUM_REGS_C) begin
      stored_b_s = regs_q[rs2];
    end else begin
      stored_b_s = '0;
    end
  end

  // Read ports.
  always_comb begin
    busA = sel_read(rs,  stored_a_s, wr_commit_s, waddr_s, busW);
    busB = sel_read(rs2, stored_b_s, wr_commit_s, waddr_s, busW);
  end

  // Clear-sweep next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + (ADDR_W+1)'(1);
        if (ptr_q == LAST_C) begin
          state_d = DONE;
        end else begin
          state_d = CLEAR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, pointer and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      busy_q       <= (state_d == CLEAR);
      clear_done_q <= (state_d == DONE);
      wr_drop_q    <= wr_drop_d;
    end
  end

  // Storage array: normal writes only in IDLE, sweep writes only in CLEAR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit_s) begin
      regs_q[waddr_s] <= busW;
    end else if (state_q == CLEAR) begin
      regs_q[ptr_q[ADDR_W-1:0]] <= '0;
    end
  end

  assign busy       = busy_q;
  assign clear_done = clear_done_q;
  assign wr_drop    = wr_drop_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench: two instances (default config, and 24 regs / no r0 / no bypass) share stimulus;
// a reference model pushes per-cycle expectations, a monitor pops and compares before each edge.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic [31:0] busW = 32'd0;
  logic        r_type = 1'b0, reg_wr = 1'b0, clear = 1'b0;

  logic [31:0] busA0, busB0, busA1, busB1;
  logic        busy0, done0, drop0, busy1, done1, drop1;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(32), .NUM_REGS(32), .R0_ZERO(1), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .rs(rs), .rs2(rs2), .rd(rd), .busW(busW), .r_type(r_type),
    .reg_wr(reg_wr), .clear(clear), .busA(busA0), .busB(busB0), .busy(busy0),
    .clear_done(done0), .wr_drop(drop0));

  reg_file_param #(.DATA_W(32), .NUM_REGS(24), .R0_ZERO(0), .BYPASS(0)) u_dut24 (
    .clk(clk), .reset(reset), .rs(rs), .rs2(rs2), .rd(rd), .busW(busW), .r_type(r_type),
    .reg_wr(reg_wr), .clear(clear), .busA(busA1), .busB(busB1), .busy(busy1),
    .clear_done(done1), .wr_drop(drop1));

  typedef struct packed {
    logic [1:0][31:0] a;
    logic [1:0][31:0] b;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0]       drop;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: register contents, sweep progress (-1 idle, 0..N-1 clearing, N done)
  logic [31:0] m_regs [2][256];
  int          m_n   [2] = '{32, 24};
  bit          m_r0  [2] = '{1'b1, 1'b0};
  bit          m_byp [2] = '{1'b1, 1'b0};
  int          m_sw  [2];
  bit          m_drop[2];

  function automatic logic [31:0] mread(int k, int addr, bit commit, int wa, logic [31:0] w);
    if (addr >= m_n[k]) return 32'd0;
    if (m_r0[k] && addr == 0) return 32'd0;
    if (m_byp[k] && commit && addr == wa) return w;
    return m_regs[k][addr];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) m_regs[k][i] = 32'd0;
      m_sw[k]   = -1;
      m_drop[k] = 1'b0;
    end
  endtask

  task automatic step(input bit wr, input bit rt, input bit clr, input int ra, input int rb,
                      input int rdd, input logic [31:0] w);
    exp_t e;
    int   wa;
    bit   idle, commit;
    @(negedge clk);
    reset = 1'b1; reg_wr = wr; r_type = rt; clear = clr;
    rs = 5'(ra); rs2 = 5'(rb); rd = 5'(rdd); busW = w;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      wa     = rt ? rdd : rb;
      idle   = (m_sw[k] < 0);
      commit = wr && idle && (wa < m_n[k]) && !(m_r0[k] && wa == 0);
      e.a[k]    = mread(k, ra, commit, wa, w);
      e.b[k]    = mread(k, rb, commit, wa, w);
      e.busy[k] = (m_sw[k] >= 0) && (m_sw[k] < m_n[k]);
      e.done[k] = (m_sw[k] == m_n[k]);
      e.drop[k] = m_drop[k];
      m_drop[k] = wr && (!idle || wa >= m_n[k]);
      if (commit) m_regs[k][wa] = w;
      if (m_sw[k] < 0) begin
        if (clr) m_sw[k] = 0;
      end else if (m_sw[k] < m_n[k]) begin
        m_regs[k][m_sw[k]] = 32'd0;
        m_sw[k]++;
      end else begin
        m_sw[k] = -1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic apply_reset(input int ra, input int rb);
    @(negedge clk);
    reset = 1'b0; reg_wr = 1'b0; clear = 1'b0; rs = 5'(ra); rs2 = 5'(rb);
    model_reset();
    exp_q.push_back('0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: compare every output of both instances shortly before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busA0", busA0, e.a[0]);           chk("busB0", busB0, e.b[0]);
        chk("busy0", 32'(busy0), 32'(e.busy[0])); chk("done0", 32'(done0), 32'(e.done[0]));
        chk("drop0", 32'(drop0), 32'(e.drop[0]));
        chk("busA24", busA1, e.a[1]);          chk("busB24", busB1, e.b[1]);
        chk("busy24", 32'(busy1), 32'(e.busy[1])); chk("done24", 32'(done1), 32'(e.done[1]));
        chk("drop24", 32'(drop1), 32'(e.drop[1]));
      end
    end
  end

  initial begin
    model_reset();
    apply_reset(5, 7);
    // Basic write then read back
    step(1, 1, 0, 0, 0, 5, 32'hDEADBEEF);
    step(0, 1, 0, 5, 5, 0, 32'h0);
    // Same-cycle write and read of r7 (forwarded on one instance only)
    step(1, 1, 0, 7, 7, 7, 32'h0000_1234);
    step(0, 1, 0, 7, 7, 0, 32'h0);
    // r0 write: masked on one instance, stored on the other
    step(1, 1, 0, 0, 0, 0, 32'hFFFF_FFFF);
    step(0, 1, 0, 0, 0, 0, 32'h0);
    // Out-of-range write on the 24-entry instance, via rs2 destination
    step(1, 0, 0, 30, 30, 0, 32'hCAFE_F00D);
    step(0, 1, 0, 30, 30, 0, 32'h0);
    // Fill every register with i+1, then sweep with a write attempted mid-sweep
    for (int i = 0; i < 32; i++) step(1, 1, 0, i, 31 - i, i, 32'(i + 1));
    for (int i = 0; i < 32; i++) step(0, 1, 0, i, (i + 16) % 32, 0, 32'h0);
    step(1, 1, 1, 3, 4, 3, 32'h5555_AAAA);
    for (int i = 0; i < 36; i++) begin
      if (i == 5) step(1, 1, 1, 2, 9, 9, 32'h7777_0000);
      else        step(0, 1, (i == 20), i % 32, (i * 7) % 32, 0, 32'h0);
    end
    for (int i = 0; i < 32; i++) step(0, 1, 0, i, 31 - i, 0, 32'h0);
    // Randomised traffic with occasional sweeps
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
    end
    for (int i = 0; i < 40; i++) step(0, 1, 0, i % 32, (i + 1) % 32, 0, 32'h0);
    // Reset at sweep cycle 10, then normal operation
    for (int i = 1; i < 24; i++) step(1, 1, 0, i, i, i, 32'hA000_0000 + 32'(i));
    step(0, 1, 1, 1, 2, 0, 32'h0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 20 - i, 12 + i, 0, 32'h0);
    apply_reset(21, 13);
    step(1, 1, 0, 9, 22, 9, 32'h1357_9BDF);
    for (int i = 0; i < 32; i++) step(0, 1, 0, i, 31 - i, 0, 32'h0);
    #8;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
